// File: rtl/eightbit_io_pkg.sv
// Shared register map for the 8-bit button I/O device.
package eightbit_io_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_LEVELS  = 5'd8;
  localparam logic [ADDR_W-1:0] ADDR_PRESS   = 5'd9;
  localparam logic [ADDR_W-1:0] ADDR_RELEASE = 5'd10;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 5'd12;

endpackage

// File: rtl/debounced_button_device_if.sv
// Register access bus: select, direction, address and write data.
interface debounced_button_device_if;
  import eightbit_io_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              enable;
  logic              mode;
  logic [DATA_W-1:0] data_in;

  modport master (output address, enable, mode, data_in);
  modport slave  (input  address, enable, mode, data_in);

endinterface

// File: rtl/button_debouncer.sv
// One button channel: 2-flop synchronizer, stability counter and edge pulses.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          done;

  // rise/fall fire on the same edge that flips stable
  assign done = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise = done & ~stable;
  assign fall = done & stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (done) begin
        cnt    <= '0;
        stable <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounced_button_device.sv
// Debounced button bank with press/release flags, irq mask and register readout.
module debounced_button_device
  import eightbit_io_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  debounced_button_device_if.slave     bus,
  output wire  [DATA_W-1:0]            data_out,
  input  logic [NUM_BUTTONS-1:0]       button_state,
  output logic                         irq
);

  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] fall;
  logic [NUM_BUTTONS-1:0] press_flags;
  logic [NUM_BUTTONS-1:0] release_flags;
  logic [NUM_BUTTONS-1:0] mask;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_en;
  logic                   press_clr;
  logic                   release_clr;
  logic                   mask_wr;
  logic                   unused_data_in;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (button_state[g]),
      .stable (stable[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

  assign rd_en       = bus.enable && bus.mode;
  assign press_clr   = rd_en && (bus.address == ADDR_PRESS);
  assign release_clr = rd_en && (bus.address == ADDR_RELEASE);
  assign mask_wr     = bus.enable && !bus.mode && (bus.address == ADDR_MASK);
  assign unused_data_in = ^bus.data_in;

  // a new event in the clearing cycle survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_flags   <= '0;
      release_flags <= '0;
      mask          <= '0;
      irq           <= 1'b0;
    end else begin
      press_flags   <= (press_flags & ~{NUM_BUTTONS{press_clr}}) | rise;
      release_flags <= (release_flags & ~{NUM_BUTTONS{release_clr}}) | fall;
      if (mask_wr) mask <= bus.data_in[NUM_BUTTONS-1:0];
      irq <= |(press_flags & mask);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (bus.address == ADDR_W'(i)) rd_data[0] = stable[i];
    end
    case (bus.address)
      ADDR_LEVELS:  rd_data[NUM_BUTTONS-1:0] = stable;
      ADDR_PRESS:   rd_data[NUM_BUTTONS-1:0] = press_flags;
      ADDR_RELEASE: rd_data[NUM_BUTTONS-1:0] = release_flags;
      ADDR_MASK:    rd_data[NUM_BUTTONS-1:0] = mask;
      default:      ;
    endcase
  end

  assign data_out = rd_en ? rd_data : 'z;

endmodule
